destruct_sequencer: RTL and testbench
=====================================

Name: destruct_sequencer

Overview:
- Central controller for the self-destruct chain.
- Takes debounced switch levels and the 10 ms tick, and votes 2-of-3 on danger/damaged/immobilized.
- Requires the vote to hold before arming, then runs the staged LED countdown, supports abort via the combat line, and drives the detonation blink.
- Replaces the ad-hoc voter, counter and blinker chain with one FSM feeding the LED pins.

Parameters:
- ARM_TICKS, 50: consecutive ticks the vote and in_combat must hold before countdown starts (≥1).
- STAGE_TICKS, 100: ticks per countdown stage (≥1).
- STAGES, 8: number of countdown stages, i.e. lit LEDs at detonation (1..8).
- COOLDOWN_TICKS, 200: ticks spent in COOLDOWN after an abort (≥1).
- BLINK_TICKS, 33: ticks per half-period of the detonation blink (≥1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; overrides everything
- tick  in  1  one-cycle enable pulse, every 10 ms
- in_combat  in  1  debounced; 0 = abort / not permitted
- in_danger  in  1  debounced fault input
- damaged  in  1  debounced fault input
- immobilized  in  1  debounced fault input
- leds  out  8  LED pattern
- state  out  3  current FSM state encoding
- armed  out  1  1 while in COUNTDOWN
- boom  out  1  1 while in DETONATE

Behaviour:
- Definition: vote = (in_danger&damaged) | (in_danger&immobilized) | (damaged&immobilized), combinational.
- Evaluation timing: all state transitions and counter updates occur only on cycles with tick=1. The only exception is reset.
- Outputs are registered.
- Reset: state=IDLE, all counters=0, leds=8'h00, armed=0, boom=0, blink phase=0.
- State encodings: IDLE=0, ARMING=1, COUNTDOWN=2, DETONATE=3, COOLDOWN=4.
- IDLE:
  - On a tick with vote & in_combat: go to ARMING, arm_cnt=0.
  - leds=0.
- ARMING:
  - On a tick, if !vote or !in_combat: go to IDLE, arm_cnt=0.
  - Otherwise, if arm_cnt==ARM_TICKS-1: go to COUNTDOWN, stage=0, stage_cnt=0. Else arm_cnt+1.
  - Net effect: COUNTDOWN is entered on the ARM_TICKS-th qualifying tick after ARMING entry.
  - leds=0.
- COUNTDOWN:
  - armed=1.
  - vote is ignored once here: the countdown is committed.
  - On a tick, if !in_combat: go to COOLDOWN, leds=0, cool_cnt=0. Abort beats a stage advance on the same tick.
  - Otherwise, if stage_cnt==STAGE_TICKS-1: stage_cnt=0, stage+1, leds={leds[6:0],1'b1}. Else stage_cnt+1.
  - When stage becomes STAGES: go to DETONATE in the same update, blink phase=1.
  - leds is a thermometer code of width stage.
  - DETONATE is entered exactly STAGES*STAGE_TICKS ticks after COUNTDOWN entry.
- DETONATE:
  - boom=1.
  - Sticky: left only by reset; all inputs ignored.
  - leds = phase ? mask : 8'h00, where mask holds the low STAGES bits set.
  - Phase toggles every BLINK_TICKS ticks (blink_cnt wraps at BLINK_TICKS-1).
- COOLDOWN:
  - leds=0.
  - vote and in_combat are ignored.
  - On the tick with cool_cnt==COOLDOWN_TICKS-1: go to IDLE. Else cool_cnt+1.
  - A vote still held then re-arms only through a fresh ARMING.
- Counter widths: sized with $clog2 of the respective parameter; no counter may wrap outside the rules above.
- tick while reset=1: reset wins; no count.
- Inputs are treated as synchronous: already debounced in the clk domain.
- Unused state encodings 5..7: go to IDLE on the next clk, outputs as IDLE.

Test Plan:
Bench setup: ARM_TICKS=3, STAGE_TICKS=4, STAGES=8, COOLDOWN_TICKS=5, BLINK_TICKS=2; tick every 2nd clk.
- Reset: hold reset 3 clk with all inputs=1 -> state=0, leds=00, armed=0, boom=0.
- Full run: in_combat=1, danger=damaged=1 held -> ARMING on tick 1, COUNTDOWN on tick 4. leds=01 after 4 more ticks, 03 after 8 … FF. DETONATE and boom=1 on tick 36. leds toggles FF/00 every 2 ticks thereafter.
- Arming glitch: vote held 2 ticks, dropped 1 tick, restored -> back to IDLE, then needs a full 3 ticks again. armed stays 0 through the glitch.
- Abort: in_combat=0 on the same tick as the stage 3→4 advance -> COOLDOWN, leds=00, no advance. IDLE 5 ticks later even with vote still high.
- Committed countdown: vote drops mid-COUNTDOWN with in_combat=1 -> countdown continues unchanged to DETONATE.
- Mid-run reset: pulse reset during DETONATE, and separately mid-COUNTDOWN -> next clk state=IDLE, leds=00, boom=0, armed=0. The next arm takes a full ARM_TICKS.

Source files
------------

// File: rtl/destruct_sequencer_if.sv
// Signal bundle between the switch/tick front end and the destruct sequencer.
// The sequencer takes the slave view; the driver of switches and tick takes the master view.
interface destruct_sequencer_if;
    logic       tick;
    logic       in_combat;
    logic       in_danger;
    logic       damaged;
    logic       immobilized;
    logic [7:0] leds;
    logic [2:0] state;
    logic       armed;
    logic       boom;

    modport master (
        output tick, in_combat, in_danger, damaged, immobilized,
        input  leds, state, armed, boom
    );

    modport slave (
        input  tick, in_combat, in_danger, damaged, immobilized,
        output leds, state, armed, boom
    );
endinterface

// File: rtl/destruct_sequencer.sv
// Self-destruct sequencer.
// A 2-of-3 vote on the fault inputs must hold together with in_combat for ARM_TICKS ticks.
// After that, the staged LED countdown runs and ends in a sticky detonation blink.
// Dropping in_combat during the countdown aborts into a cooldown.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for vote & in_combat
// ARMING    | vote & in_combat must hold for ARM_TICKS consecutive ticks
// COUNTDOWN | committed; one LED per STAGE_TICKS, abort on !in_combat
// DETONATE  | sticky blink of the full LED mask, left only by reset
// COOLDOWN  | post-abort hold-off of COOLDOWN_TICKS, inputs ignored
module destruct_sequencer #(
    parameter int ARM_TICKS      = 50,
    parameter int STAGE_TICKS    = 100,
    parameter int STAGES         = 8,
    parameter int COOLDOWN_TICKS = 200,
    parameter int BLINK_TICKS    = 33
) (
    input  logic clk,
    input  logic reset,
    destruct_sequencer_if.slave bus
);

    localparam int AW = (ARM_TICKS > 1)      ? $clog2(ARM_TICKS)      : 1;
    localparam int TW = (STAGE_TICKS > 1)    ? $clog2(STAGE_TICKS)    : 1;
    localparam int SW = $clog2(STAGES + 1);
    localparam int CW = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
    localparam int BW = (BLINK_TICKS > 1)    ? $clog2(BLINK_TICKS)    : 1;

    localparam logic [7:0] LED_MASK = 8'((16'd1 << STAGES) - 16'd1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARMING    = 3'd1,
        S_COUNTDOWN = 3'd2,
        S_DETONATE  = 3'd3,
        S_COOLDOWN  = 3'd4
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_arm_cnt;
    logic [TW-1:0] r_stage_cnt;
    logic [SW-1:0] r_stage;
    logic [CW-1:0] r_cool_cnt;
    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;
    logic [7:0]    r_leds;
    logic          r_armed;
    logic          r_boom;

    state_t        w_state_nxt;
    logic [AW-1:0] w_arm_cnt_nxt;
    logic [TW-1:0] w_stage_cnt_nxt;
    logic [SW-1:0] w_stage_nxt;
    logic [SW-1:0] w_stage_inc;
    logic [CW-1:0] w_cool_cnt_nxt;
    logic [BW-1:0] w_blink_cnt_nxt;
    logic          w_phase_nxt;
    logic [7:0]    w_leds_nxt;
    logic          w_vote;

    assign w_vote      = (bus.in_danger & bus.damaged) |
                         (bus.in_danger & bus.immobilized) |
                         (bus.damaged & bus.immobilized);
    assign w_stage_inc = r_stage + SW'(1);

    // State, counters and all outputs are registered; reset overrides any tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_arm_cnt   <= '0;
            r_stage_cnt <= '0;
            r_stage     <= '0;
            r_cool_cnt  <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_leds      <= 8'h00;
            r_armed     <= 1'b0;
            r_boom      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_arm_cnt   <= w_arm_cnt_nxt;
            r_stage_cnt <= w_stage_cnt_nxt;
            r_stage     <= w_stage_nxt;
            r_cool_cnt  <= w_cool_cnt_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_phase     <= w_phase_nxt;
            r_leds      <= w_leds_nxt;
            r_armed     <= (w_state_nxt == S_COUNTDOWN);
            r_boom      <= (w_state_nxt == S_DETONATE);
        end
    end

    // Next-state and next-output logic; everything except recovery from an illegal state waits for tick.
    always_comb begin
        w_state_nxt     = r_state;
        w_arm_cnt_nxt   = r_arm_cnt;
        w_stage_cnt_nxt = r_stage_cnt;
        w_stage_nxt     = r_stage;
        w_cool_cnt_nxt  = r_cool_cnt;
        w_blink_cnt_nxt = r_blink_cnt;
        w_phase_nxt     = r_phase;
        w_leds_nxt      = r_leds;

        case (r_state)
            S_IDLE: begin
                w_leds_nxt = 8'h00;
                if (bus.tick && w_vote && bus.in_combat) begin
                    w_state_nxt   = S_ARMING;
                    w_arm_cnt_nxt = '0;
                end
            end

            S_ARMING: begin
                w_leds_nxt = 8'h00;
                if (bus.tick) begin
                    if (!w_vote || !bus.in_combat) begin
                        w_state_nxt   = S_IDLE;
                        w_arm_cnt_nxt = '0;
                    end else if (r_arm_cnt == AW'(ARM_TICKS - 1)) begin
                        w_state_nxt     = S_COUNTDOWN;
                        w_stage_nxt     = '0;
                        w_stage_cnt_nxt = '0;
                    end else begin
                        w_arm_cnt_nxt = r_arm_cnt + AW'(1);
                    end
                end
            end

            S_COUNTDOWN: begin
                // Vote is deliberately not looked at here: once counting, only in_combat can stop it.
                if (bus.tick) begin
                    if (!bus.in_combat) begin
                        w_state_nxt    = S_COOLDOWN;
                        w_leds_nxt     = 8'h00;
                        w_cool_cnt_nxt = '0;
                    end else if (r_stage_cnt == TW'(STAGE_TICKS - 1)) begin
                        w_stage_cnt_nxt = '0;
                        w_stage_nxt     = w_stage_inc;
                        w_leds_nxt      = {r_leds[6:0], 1'b1};
                        if (w_stage_inc == SW'(STAGES)) begin
                            w_state_nxt     = S_DETONATE;
                            w_phase_nxt     = 1'b1;
                            w_blink_cnt_nxt = '0;
                            w_leds_nxt      = LED_MASK;
                        end
                    end else begin
                        w_stage_cnt_nxt = r_stage_cnt + TW'(1);
                    end
                end
            end

            S_DETONATE: begin
                if (bus.tick) begin
                    if (r_blink_cnt == BW'(BLINK_TICKS - 1)) begin
                        w_blink_cnt_nxt = '0;
                        w_phase_nxt     = ~r_phase;
                        w_leds_nxt      = r_phase ? 8'h00 : LED_MASK;
                    end else begin
                        w_blink_cnt_nxt = r_blink_cnt + BW'(1);
                    end
                end
            end

            S_COOLDOWN: begin
                w_leds_nxt = 8'h00;
                if (bus.tick) begin
                    if (r_cool_cnt == CW'(COOLDOWN_TICKS - 1)) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cool_cnt_nxt = r_cool_cnt + CW'(1);
                    end
                end
            end

            default: begin
                w_state_nxt     = S_IDLE;
                w_arm_cnt_nxt   = '0;
                w_stage_cnt_nxt = '0;
                w_stage_nxt     = '0;
                w_cool_cnt_nxt  = '0;
                w_blink_cnt_nxt = '0;
                w_phase_nxt     = 1'b0;
                w_leds_nxt      = 8'h00;
            end
        endcase
    end

    assign bus.leds  = r_leds;
    assign bus.state = r_state;
    assign bus.armed = r_armed;
    assign bus.boom  = r_boom;

endmodule

// File: tb/tb_destruct_sequencer.sv
// Scoreboard bench for destruct_sequencer (ARM=3, STAGE=4, STAGES=8, COOLDOWN=5, BLINK=2).
// Stimulus pushes the expected outputs for every tick/reset cycle it issues.
// A monitor pops one entry after each such clock edge and compares it.
module tb_destruct_sequencer;

    localparam logic [2:0] IDLE = 3'd0, ARMING = 3'd1, CD = 3'd2, DET = 3'd3, COOL = 3'd4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    destruct_sequencer_if bus ();

    destruct_sequencer #(
        .ARM_TICKS(3), .STAGE_TICKS(4), .STAGES(8), .COOLDOWN_TICKS(5), .BLINK_TICKS(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] leds;
        logic       armed;
        logic       boom;
    } exp_t;

    exp_t  q_exp[$];
    string q_name[$];
    int    checks = 0;
    int    errors = 0;

    function automatic void expect_out(input logic [2:0] st, input logic [7:0] ld, input string nm);
        exp_t e;
        e.st    = st;
        e.leds  = ld;
        e.armed = (st == CD);
        e.boom  = (st == DET);
        q_exp.push_back(e);
        q_name.push_back(nm);
    endfunction

    // Thermometer pattern for n lit LEDs (n = 0..8).
    function automatic logic [7:0] therm(input int n);
        logic [7:0] ff;
        ff = 8'hFF;
        return (n == 0) ? 8'h00 : (ff >> (8 - n));
    endfunction

    // Called at a negedge; one tick cycle, returns at the negedge two clocks later.
    task automatic do_tick(input logic c, input logic dg, input logic dm, input logic im,
                           input logic [2:0] st, input logic [7:0] ld, input string nm);
        bus.in_combat   = c;
        bus.in_danger   = dg;
        bus.damaged     = dm;
        bus.immobilized = im;
        bus.tick        = 1'b1;
        expect_out(st, ld, nm);
        @(negedge clk);
        bus.tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            reset = 1'b1;
            expect_out(IDLE, 8'h00, "reset");
            @(negedge clk);
        end
        reset = 1'b0;
    endtask

    // Three qualifying ticks in ARMING, then COUNTDOWN on the fourth.
    task automatic arm_full(input string nm);
        do_tick(1, 1, 1, 0, ARMING, 8'h00, nm);
        do_tick(1, 1, 1, 0, ARMING, 8'h00, nm);
        do_tick(1, 1, 1, 0, ARMING, 8'h00, nm);
        do_tick(1, 1, 1, 0, CD,     8'h00, nm);
    endtask

    // Countdown ticks k = 1..kmax after COUNTDOWN entry; danger drops from tick drop_at on.
    task automatic run_countdown(input int kmax, input int drop_at, input string nm);
        for (int k = 1; k <= kmax; k++) begin
            if (k == 32)
                do_tick(1, (k < drop_at), 1, 0, DET, 8'hFF, nm);
            else
                do_tick(1, (k < drop_at), 1, 0, CD, therm(k / 4), nm);
        end
    endtask

    // Monitor: compare after every clock edge where tick or reset was applied.
    initial begin : monitor
        exp_t  e;
        exp_t  act;
        string nm;
        forever begin
            @(posedge clk);
            if (bus.tick === 1'b1 || reset === 1'b1) begin
                #1;
                act = {bus.state, bus.leds, bus.armed, bus.boom};
                checks++;
                if (q_exp.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_sample: got state=%0d leds=%02h, no expectation queued",
                             act.st, act.leds);
                end else begin
                    e  = q_exp.pop_front();
                    nm = q_name.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL %s @%0t: got state=%0d leds=%02h armed=%b boom=%b, want state=%0d leds=%02h armed=%b boom=%b",
                                 nm, $time, act.st, act.leds, act.armed, act.boom,
                                 e.st, e.leds, e.armed, e.boom);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset           = 1'b0;
        bus.tick        = 1'b0;
        bus.in_combat   = 1'b0;
        bus.in_danger   = 1'b0;
        bus.damaged     = 1'b0;
        bus.immobilized = 1'b0;
        @(negedge clk);

        // Reset with every input (including tick) high.
        bus.tick        = 1'b1;
        bus.in_combat   = 1'b1;
        bus.in_danger   = 1'b1;
        bus.damaged     = 1'b1;
        bus.immobilized = 1'b1;
        do_reset(3);
        bus.tick = 1'b0;

        // Full run to detonation.
        arm_full("full_arm");
        run_countdown(32, 1000, "full_cd");
        // Blink; inputs ignored (combat low, no vote).
        for (int j = 1; j <= 8; j++)
            do_tick(0, 0, 0, 0, DET, (((j / 2) % 2) == 0) ? 8'hFF : 8'h00, "blink");

        // Reset during DETONATE, then a full arm again.
        do_reset(1);
        arm_full("rearm_after_det");
        run_countdown(6, 1000, "cd_partial");
        // Reset mid-COUNTDOWN, then a full arm again.
        do_reset(1);
        arm_full("rearm_after_cd");

        // Committed countdown: vote drops from countdown tick 5 on.
        run_countdown(32, 5, "committed");

        // Arming glitch: two qualifying ticks, one without vote, then full arming again.
        do_reset(1);
        do_tick(1, 1, 1, 0, ARMING, 8'h00, "glitch");
        do_tick(1, 1, 1, 0, ARMING, 8'h00, "glitch");
        do_tick(1, 1, 0, 0, IDLE,   8'h00, "glitch_drop");
        arm_full("glitch_rearm");

        // Abort on the tick that would advance stage 3 to 4.
        run_countdown(15, 1000, "pre_abort");
        do_tick(0, 1, 1, 0, COOL, 8'h00, "abort");
        do_tick(1, 1, 1, 0, COOL, 8'h00, "cooldown");
        do_tick(0, 1, 1, 0, COOL, 8'h00, "cooldown");
        do_tick(1, 1, 1, 0, COOL, 8'h00, "cooldown");
        do_tick(1, 1, 1, 0, COOL, 8'h00, "cooldown");
        do_tick(1, 1, 1, 0, IDLE, 8'h00, "cooldown_end");
        do_tick(1, 1, 1, 0, ARMING, 8'h00, "fresh_arm");
        do_tick(1, 1, 1, 0, ARMING, 8'h00, "fresh_arm");

        repeat (4) @(negedge clk);
        checks++;
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", q_exp.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
